// File: rtl/ro_entropy_combiner_pkg.sv
// Shared defaults, pair-FSM encoding and the reduction-tree depth helper
// for the ring-oscillator entropy combiner.
package ro_entropy_combiner_pkg;

    localparam int DEF_NUM_RO      = 4;
    localparam int DEF_NUM_GATES   = 5;
    localparam int DEF_GATE_DELAY  = 1;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_XOR_PIPE    = 1;
    localparam int DEF_OUT_W       = 8;
    localparam int DEF_OVF_W       = 8;

    typedef enum logic {
        PAIR_IDLE       = 1'b0,
        PAIR_HAVE_FIRST = 1'b1
    } pair_state_t;

    // Registered levels needed to reduce n operands pairwise (at least one).
    function automatic int tree_depth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro.sv
// Ring-oscillator channel. This clocked Johnson-ring model advances one stage
// every GATE_DELAY clocks so the combiner can be simulated; silicon binds the placed ring macro.
module ro #(
    parameter int NUM_GATES  = 5,
    parameter int GATE_DELAY = 1,
    parameter int SEED       = 1
) (
    input  logic clock,
    input  logic enable,
    output logic ro_out
);
    localparam logic [NUM_GATES-1:0] SEED_V = NUM_GATES'(SEED);

    logic [NUM_GATES-1:0] r_ring;
    logic [15:0]          r_div;
    logic                 w_tick;

    assign w_tick = (r_div == 16'(GATE_DELAY - 1));

    // A gated ring collapses to its rest state and restarts from it.
    always_ff @(posedge clock) begin
        if (!enable) begin
            r_ring <= SEED_V;
            r_div  <= '0;
        end else begin
            r_div <= w_tick ? 16'd0 : r_div + 16'd1;
            if (w_tick) begin
                r_ring <= {r_ring[NUM_GATES-2:0], ~r_ring[NUM_GATES-1]};
            end
        end
    end

    assign ro_out = r_ring[NUM_GATES-1];

endmodule

// File: rtl/xor_tree_pipe.sv
// XOR reduction of WIDTH bits: one registered XOR (PIPE=0) or a pairwise tree
// with a register on every level (PIPE=1); odd operands ride through a register.
module xor_tree_pipe
    import ro_entropy_combiner_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PIPE  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    output logic             out
);
    generate
        if (PIPE == 0) begin : g_flat
            logic r_out;
            always_ff @(posedge clock) begin
                if (!reset_n || clear) begin
                    r_out <= 1'b0;
                end else begin
                    r_out <= ^in;
                end
            end
            assign out = r_out;
        end else begin : g_pipe
            localparam int DEPTH = tree_depth(WIDTH);
            logic [WIDTH-1:0] w_lvl [DEPTH+1];

            assign w_lvl[0] = in;

            // Zero padding lets every level use the same pairing; upper entries settle to 0.
            for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
                logic [2*WIDTH-1:0] w_pad;
                logic [WIDTH-1:0]   w_pair;
                logic [WIDTH-1:0]   r_level;

                assign w_pad = {{WIDTH{1'b0}}, w_lvl[gi]};
                for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pair
                    assign w_pair[gj] = w_pad[2*gj] ^ w_pad[2*gj+1];
                end

                always_ff @(posedge clock) begin
                    if (!reset_n || clear) begin
                        r_level <= '0;
                    end else begin
                        r_level <= w_pair;
                    end
                end
                assign w_lvl[gi+1] = r_level;
            end

            assign out = ^w_lvl[DEPTH];
        end
    endgenerate

endmodule

// File: rtl/ro_entropy_combiner.sv
// Ring-oscillator TRNG front end: synchronise, mask and XOR the channels,
// optionally von Neumann debias, and pack bits into words on a valid/ready port.
module ro_entropy_combiner
    import ro_entropy_combiner_pkg::*;
#(
    parameter int NUM_RO      = DEF_NUM_RO,
    parameter int NUM_GATES   = DEF_NUM_GATES,
    parameter int GATE_DELAY  = DEF_GATE_DELAY,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int XOR_PIPE    = DEF_XOR_PIPE,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int OVF_W       = DEF_OVF_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [NUM_RO-1:0] ro_mask,
    input  logic              debias_en,
    input  logic              test_mode,
    input  logic              test_bit,
    output logic [OUT_W-1:0]  data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [OVF_W-1:0]  overflow
);
    localparam int              CNT_W    = $clog2(OUT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    logic              w_ro_en;
    logic [NUM_RO-1:0] w_signals;
    logic [NUM_RO-1:0] w_masked;
    logic              w_tree_out;
    logic              w_raw_bit;

    assign w_ro_en = enable & reset_n;

    generate
        for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_ro
            logic [SYNC_STAGES-1:0] r_sync;

            ro #(
                .NUM_GATES  (NUM_GATES),
                .GATE_DELAY (GATE_DELAY),
                .SEED       (gi + 1)
            ) u_ro (
                .clock  (clock),
                .enable (w_ro_en),
                .ro_out (w_signals[gi])
            );

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_signals[gi]};
                end
            end
            assign w_masked[gi] = r_sync[SYNC_STAGES-1] & ro_mask[gi];
        end
    endgenerate

    xor_tree_pipe #(
        .WIDTH (NUM_RO),
        .PIPE  (XOR_PIPE)
    ) u_tree (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (~enable),
        .in      (w_masked),
        .out     (w_tree_out)
    );

    assign w_raw_bit = test_mode ? test_bit : w_tree_out;

    // Pair FSM: a debias_en toggle makes this cycle's bit the first of a new pair.
    pair_state_t r_state, w_state_eff, w_state_next;
    logic        r_first, w_first_next;
    logic        r_debias_q;
    logic        w_accept;
    logic        w_acc_bit;

    assign w_state_eff = (debias_en != r_debias_q) ? PAIR_IDLE : r_state;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= PAIR_IDLE;
            r_first    <= 1'b0;
            r_debias_q <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_first    <= w_first_next;
            r_debias_q <= debias_en;
        end
    end

    always_comb begin
        w_state_next = PAIR_IDLE;
        w_first_next = r_first;
        if (enable && debias_en) begin
            case (w_state_eff)
                PAIR_IDLE: begin
                    w_state_next = PAIR_HAVE_FIRST;
                    w_first_next = w_raw_bit;
                end
                default: w_state_next = PAIR_IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept  = 1'b0;
        w_acc_bit = w_raw_bit;
        if (enable) begin
            if (!debias_en) begin
                w_accept = 1'b1;
            end else if (w_state_eff == PAIR_HAVE_FIRST && r_first != w_raw_bit) begin
                w_accept  = 1'b1;
                w_acc_bit = r_first;
            end
        end
    end

    // Packer and output word register.
    logic [OUT_W-2:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic [OVF_W-1:0] r_ovf;
    logic             w_word_done;
    logic [OUT_W-1:0] w_word;

    assign w_word_done = w_accept && (r_cnt == CNT_LAST);
    assign w_word      = {w_acc_bit, r_shift};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= '0;
        end else begin
            if (!enable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_shift[r_cnt] <= w_acc_bit;
                    r_cnt          <= r_cnt + 1'b1;
                end
            end

            // A completed word may replace the held one only if that word leaves this edge.
            if (w_word_done && (!r_valid || data_ready)) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_word_done) begin
                if (r_ovf != {OVF_W{1'b1}}) begin
                    r_ovf <= r_ovf + 1'b1;
                end
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_ro_entropy_combiner.sv
// Directed bench for ro_entropy_combiner: reset, raw packing, debiasing,
// back-pressure, simultaneous transfer/complete and the ring-oscillator path.
module tb_ro_entropy_combiner;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [3:0] ro_mask;
    logic       debias_en;
    logic       test_mode;
    logic       test_bit;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic [7:0] overflow;

    int n_checks = 0;
    int n_errors = 0;

    ro_entropy_combiner #(
        .NUM_RO      (4),
        .NUM_GATES   (5),
        .GATE_DELAY  (1),
        .SYNC_STAGES (2),
        .XOR_PIPE    (1),
        .OUT_W       (8),
        .OVF_W       (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .ro_mask    (ro_mask),
        .debias_en  (debias_en),
        .test_mode  (test_mode),
        .test_bit   (test_bit),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        enable   = 1'b1;
        test_bit = b;
        step();
    endtask

    task automatic idle_cycle();
        enable = 1'b0;
        step();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    logic [1:0] pairs [12];
    logic [7:0] byte_v;

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        ro_mask    = 4'h0;
        debias_en  = 1'b0;
        test_mode  = 1'b1;
        test_bit   = 1'b0;
        data_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            enable     = 1'($urandom);
            ro_mask    = 4'($urandom);
            debias_en  = 1'($urandom);
            test_mode  = 1'($urandom);
            test_bit   = 1'($urandom);
            data_ready = 1'($urandom);
            step();
            check("rst_data", 32'(data), 32'h0);
            check("rst_valid", 32'(data_valid), 32'h0);
            check("rst_ovf", 32'(overflow), 32'h0);
        end
        reset_n    = 1'b1;
        ro_mask    = 4'h0;
        debias_en  = 1'b0;
        test_mode  = 1'b1;
        data_ready = 1'b1;
        idle_cycle();

        // Raw pack: 1,0,1,1,0,0,0,1 -> 8'h8D, valid for exactly one cycle
        byte_v = 8'h8D;
        for (int i = 0; i < 8; i++) begin
            send_bit(byte_v[i]);
            if (i < 7) check("raw_valid_early", 32'(data_valid), 32'h0);
        end
        check("raw_data", 32'(data), 32'h8D);
        check("raw_valid", 32'(data_valid), 32'h1);
        idle_cycle();
        check("raw_valid_drop", 32'(data_valid), 32'h0);

        // Debias: emitted 0,1,1,1,0,0,1,0 (00/11 dropped) -> 8'h4E
        pairs = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b10,
                  2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        data_ready = 1'b0;
        debias_en  = 1'b1;
        for (int p = 0; p < 12; p++) begin
            send_bit(pairs[p][1]);
            send_bit(pairs[p][0]);
            if (p == 8) check("db_valid_early", 32'(data_valid), 32'h0);
        end
        check("db_data", 32'(data), 32'h4E);
        check("db_valid", 32'(data_valid), 32'h1);
        debias_en  = 1'b0;
        data_ready = 1'b1;
        idle_cycle();
        check("db_drain", 32'(data_valid), 32'h0);

        // Back-pressure: three words, first held, two dropped
        data_ready = 1'b0;
        send_byte(8'hA5);
        check("bp_w1_data", 32'(data), 32'hA5);
        check("bp_w1_ovf", 32'(overflow), 32'h0);
        send_byte(8'h3C);
        check("bp_w2_data", 32'(data), 32'hA5);
        check("bp_w2_ovf", 32'(overflow), 32'h1);
        send_byte(8'hF0);
        check("bp_w3_data", 32'(data), 32'hA5);
        check("bp_w3_valid", 32'(data_valid), 32'h1);
        check("bp_w3_ovf", 32'(overflow), 32'h2);
        data_ready = 1'b1;
        idle_cycle();
        check("bp_drain", 32'(data_valid), 32'h0);

        // Simultaneous transfer and completion
        data_ready = 1'b0;
        send_byte(8'h11);
        check("sim_held", 32'(data), 32'h11);
        byte_v = 8'h96;
        for (int i = 0; i < 7; i++) send_bit(byte_v[i]);
        data_ready = 1'b1;
        send_bit(byte_v[7]);
        check("sim_data", 32'(data), 32'h96);
        check("sim_valid", 32'(data_valid), 32'h1);
        check("sim_ovf", 32'(overflow), 32'h2);
        idle_cycle();
        check("sim_drain", 32'(data_valid), 32'h0);

        // Real ROs, all channels masked: every word is zero
        begin
            int words;
            words      = 0;
            test_mode  = 1'b0;
            ro_mask    = 4'b0000;
            data_ready = 1'b1;
            for (int i = 0; i < 20; i++) begin
                send_bit(1'b1);
                if (data_valid) begin
                    words++;
                    check("ro0_data", 32'(data), 32'h0);
                end
            end
            idle_cycle();
            check("ro0_words", 32'(words), 32'd2);
        end

        // Real ROs, full mask, enable dropped mid-word
        data_ready = 1'b0;
        test_mode  = 1'b1;
        send_byte(8'h5A);
        check("tog_held", 32'(data), 32'h5A);
        test_mode = 1'b0;
        ro_mask   = 4'b1111;
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        idle_cycle();
        idle_cycle();
        check("tog_off_valid", 32'(data_valid), 32'h1);
        check("tog_off_data", 32'(data), 32'h5A);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        check("tog_7_ovf", 32'(overflow), 32'h2);
        check("tog_7_data", 32'(data), 32'h5A);
        send_bit(1'b0);
        check("tog_8_ovf", 32'(overflow), 32'h3);
        check("tog_8_data", 32'(data), 32'h5A);
        data_ready = 1'b1;
        idle_cycle();
        check("tog_drain", 32'(data_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
